// File: rtl/hamming_dec_arbiter.sv
// Two-requester arbiter in front of one shared SECDED(11,6) decoder.
// The decoded result is tagged with the owner ID, and saturating error counters are kept for status.
module hamming_dec_arbiter #(
  parameter int CNT_W      = 8,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0,
  input  logic [11:1]      CW0,
  output logic             GNT0,
  input  logic             REQ1,
  input  logic [11:1]      CW1,
  output logic             GNT1,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             OUT_ID,
  output logic [6:1]       OUT_DATA,
  output logic [4:1]       OUT_ERROR_CODE,
  output logic             OUT_SINGLE,
  output logic             OUT_DOUBLE,
  input  logic             CLR_CNT,
  output logic [CNT_W-1:0] SINGLE_CNT,
  output logic [CNT_W-1:0] DOUBLE_CNT,
  output logic [1:0]       DBG_STATE
);

  // Handshakes: REQx & GNTx in a cycle moves CWx in at the next edge; OUT_VALID & OUT_READY
  // retires the result. OUT_* stays frozen while OUT_VALID is high and OUT_READY is low.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DECODE  = 2'd1,
    S_PRESENT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_id_q, last_id_d;
  logic [11:1]      cw_q, cw_d;
  logic             id_q, id_d;
  logic             out_valid_q, out_valid_d;
  logic             out_id_q, out_id_d;
  logic [6:1]       out_data_q, out_data_d;
  logic [4:1]       out_code_q, out_code_d;
  logic             out_single_q, out_single_d;
  logic             out_double_q, out_double_d;
  logic [CNT_W-1:0] single_cnt_q, single_cnt_d;
  logic [CNT_W-1:0] double_cnt_q, double_cnt_d;

  logic        can_grant, pick1, gnt0, gnt1, accept;
  logic [4:1]  syn;
  logic        op, is_single, is_double;
  logic [11:1] corr;

  always_comb begin
    can_grant = RST_N && ((state_q == S_IDLE) || ((state_q == S_PRESENT) && OUT_READY));
    pick1     = REQ1;
    if (REQ0 && REQ1) pick1 = FIXED_PRIO ? 1'b0 : ~last_id_q;
    gnt0   = can_grant && REQ0 && !pick1;
    gnt1   = can_grant && REQ1 && pick1;
    accept = gnt0 || gnt1;
  end

  assign GNT0 = gnt0;
  assign GNT1 = gnt1;

  always_comb begin
    syn[1] = cw_q[1] ^ cw_q[3] ^ cw_q[5] ^ cw_q[7] ^ cw_q[9];
    syn[2] = cw_q[2] ^ cw_q[3] ^ cw_q[6] ^ cw_q[7] ^ cw_q[10];
    syn[3] = cw_q[4] ^ cw_q[5] ^ cw_q[6] ^ cw_q[7];
    syn[4] = cw_q[8] ^ cw_q[9] ^ cw_q[10];
    op        = ^cw_q;
    is_single = op && (syn <= 4'd10);
    is_double = (!op && (syn != 4'd0)) || (op && (syn > 4'd10));
    // Only a single error in positions 1..10 flips a bit; otherwise the raw bits pass through.
    corr = cw_q;
    for (int i = 1; i <= 10; i++) begin
      if (op && (syn == 4'(i))) corr[i] = ~cw_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    last_id_d    = last_id_q;
    cw_d         = cw_q;
    id_d         = id_q;
    out_valid_d  = out_valid_q;
    out_id_d     = out_id_q;
    out_data_d   = out_data_q;
    out_code_d   = out_code_q;
    out_single_d = out_single_q;
    out_double_d = out_double_q;
    single_cnt_d = single_cnt_q;
    double_cnt_d = double_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d      = S_PRESENT;
        out_valid_d  = 1'b1;
        out_id_d     = id_q;
        out_data_d   = {corr[10], corr[9], corr[7], corr[6], corr[5], corr[3]};
        out_code_d   = syn;
        out_single_d = is_single;
        out_double_d = is_double;
        if (is_single && (single_cnt_q != {CNT_W{1'b1}})) single_cnt_d = single_cnt_q + CNT_W'(1);
        if (is_double && (double_cnt_q != {CNT_W{1'b1}})) double_cnt_d = double_cnt_q + CNT_W'(1);
      end
      S_PRESENT: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = accept ? S_DECODE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      cw_d      = gnt1 ? CW1 : CW0;
      id_d      = gnt1;
      last_id_d = gnt1;
    end

    // Clear has priority over an increment landing in the same cycle.
    if (CLR_CNT) begin
      single_cnt_d = '0;
      double_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      last_id_q    <= 1'b1;
      cw_q         <= '0;
      id_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      out_id_q     <= 1'b0;
      out_data_q   <= '0;
      out_code_q   <= '0;
      out_single_q <= 1'b0;
      out_double_q <= 1'b0;
      single_cnt_q <= '0;
      double_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      last_id_q    <= last_id_d;
      cw_q         <= cw_d;
      id_q         <= id_d;
      out_valid_q  <= out_valid_d;
      out_id_q     <= out_id_d;
      out_data_q   <= out_data_d;
      out_code_q   <= out_code_d;
      out_single_q <= out_single_d;
      out_double_q <= out_double_d;
      single_cnt_q <= single_cnt_d;
      double_cnt_q <= double_cnt_d;
    end
  end

  assign OUT_VALID      = out_valid_q;
  assign OUT_ID         = out_id_q;
  assign OUT_DATA       = out_data_q;
  assign OUT_ERROR_CODE = out_code_q;
  assign OUT_SINGLE     = out_single_q;
  assign OUT_DOUBLE     = out_double_q;
  assign SINGLE_CNT     = single_cnt_q;
  assign DOUBLE_CNT     = double_cnt_q;
  assign DBG_STATE      = state_q;

endmodule

// File: tb/tb_hamming_dec_arbiter.sv
// Bench for hamming_dec_arbiter: scoreboarded results, arbitration order, backpressure,
// reset in flight and counter saturation/clear, with CNT_W=2 so saturation is reachable.
module tb_hamming_dec_arbiter;
  localparam int CNT_W = 2;
  localparam int RW    = 13;  // {id, data[6], code[4], single, double}

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             REQ0 = 1'b0, REQ1 = 1'b0;
  logic [11:1]      CW0 = '0, CW1 = '0;
  logic             OUT_READY = 1'b1, CLR_CNT = 1'b0;
  logic             GNT0, GNT1, OUT_VALID, OUT_ID, OUT_SINGLE, OUT_DOUBLE;
  logic [6:1]       OUT_DATA;
  logic [4:1]       OUT_ERROR_CODE;
  logic [CNT_W-1:0] SINGLE_CNT, DOUBLE_CNT;
  logic [1:0]       DBG_STATE;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_got, mon_exp;
  int            n_cmp = 0;
  int            n_err = 0;
  logic          exp_last = 1'b1;

  hamming_dec_arbiter #(.CNT_W(CNT_W), .FIXED_PRIO(1'b0)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0(REQ0), .CW0(CW0), .GNT0(GNT0),
    .REQ1(REQ1), .CW1(CW1), .GNT1(GNT1),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_ID(OUT_ID),
    .OUT_DATA(OUT_DATA), .OUT_ERROR_CODE(OUT_ERROR_CODE),
    .OUT_SINGLE(OUT_SINGLE), .OUT_DOUBLE(OUT_DOUBLE),
    .CLR_CNT(CLR_CNT), .SINGLE_CNT(SINGLE_CNT), .DOUBLE_CNT(DOUBLE_CNT),
    .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  // Syndrome as XOR of the positions of all set bits in 1..10.
  function automatic logic [RW-1:0] model(input logic id, input logic [11:1] cw);
    logic [3:0]  s;
    logic        op, sgl, dbl;
    logic [11:1] c;
    logic [5:0]  d;
    s  = 4'd0;
    op = 1'b0;
    c  = cw;
    for (int i = 1; i <= 11; i++) begin
      op ^= cw[i];
      if (i <= 10 && cw[i]) s ^= 4'(i);
    end
    sgl = op && (s <= 4'd10);
    dbl = !sgl && (s != 4'd0);
    if (sgl && s != 4'd0) c[s] = ~c[s];
    d = {c[10], c[9], c[7], c[6], c[5], c[3]};
    return {id, d, s, sgl, dbl};
  endfunction

  function automatic logic [11:1] encode(input logic [5:0] d);
    logic [11:1] c;
    logic [3:0]  s;
    c = '0;
    c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3]; c[9] = d[4]; c[10] = d[5];
    s = 4'd0;
    for (int i = 1; i <= 10; i++) if (c[i]) s ^= 4'(i);
    c[1] = s[0]; c[2] = s[1]; c[4] = s[2]; c[8] = s[3];
    c[11] = ^c[10:1];
    return c;
  endfunction

  function automatic logic [11:1] rand_cw();
    logic [11:1] c;
    int          k;
    c = encode(6'($urandom_range(0, 63)));
    k = $urandom_range(0, 2);
    for (int j = 0; j < k; j++) begin
      int p;
      p = $urandom_range(1, 11);
      c[p] = ~c[p];
    end
    return c;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    if (RST_N && OUT_VALID && OUT_READY) begin
      mon_got = {OUT_ID, OUT_DATA, OUT_ERROR_CODE, OUT_SINGLE, OUT_DOUBLE};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result got=%b expected=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_err++;
          $display("FAIL result got=%b expected=%b", mon_got, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic id, input logic [11:1] cw, output int waited);
    waited = 0;
    if (id) begin REQ1 = 1'b1; CW1 = cw; end
    else    begin REQ0 = 1'b1; CW0 = cw; end
    forever begin
      @(negedge CLK);
      if ((id ? GNT1 : GNT0) === 1'b1) break;
      waited++;
      if (waited > 60) begin
        n_cmp++; n_err++;
        $display("FAIL grant_timeout id=%0d got=no_grant expected=grant", id);
        break;
      end
    end
    if (waited <= 60) begin
      exp_q.push_back(model(id, cw));
      exp_last = id;
    end
    @(posedge CLK); #1;
    if (id) REQ1 = 1'b0; else REQ0 = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0) begin
      OUT_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge CLK); #1;
      cyc++;
      if (cyc > 100) begin
        n_cmp++; n_err++;
        $display("FAIL drain_timeout got=%0d_pending expected=0", exp_q.size());
        exp_q.delete();
      end
    end
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic clear_cnt();
    CLR_CNT = 1'b1;
    @(posedge CLK); #1;
    CLR_CNT = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N = 1'b0; REQ0 = 1'b1; REQ1 = 1'b1; CW0 = 11'h407; CW1 = 11'h417; OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_cmp++;
    if ({GNT0, GNT1, OUT_VALID, OUT_ID, OUT_DATA, OUT_ERROR_CODE, OUT_SINGLE, OUT_DOUBLE,
         SINGLE_CNT, DOUBLE_CNT} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got=%b%b%b%b_%b_%b_%b%b_%b_%b expected=all_zero", GNT0, GNT1,
               OUT_VALID, OUT_ID, OUT_DATA, OUT_ERROR_CODE, OUT_SINGLE, OUT_DOUBLE, SINGLE_CNT, DOUBLE_CNT);
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    RST_N = 1'b1;
    exp_last = 1'b1;
    exp_q.delete();
    @(posedge CLK); #1;
  endtask

  task automatic test_clean();
    int w;
    clear_cnt();
    send(1'b0, 11'h407, w);
    n_cmp++;
    if (w !== 0) begin n_err++; $display("FAIL clean_grant_wait got=%0d expected=0", w); end
    @(negedge CLK);
    n_cmp++;
    if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL clean_valid_early got=%b expected=0", OUT_VALID); end
    @(negedge CLK);
    n_cmp++;
    if ({OUT_VALID, OUT_ID, OUT_DATA, OUT_ERROR_CODE, OUT_SINGLE, OUT_DOUBLE} !== {1'b1, 1'b0, 6'b000001, 4'b0000, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL clean_fields got=%b_%b_%b_%b_%b%b expected=1_0_000001_0000_00",
               OUT_VALID, OUT_ID, OUT_DATA, OUT_ERROR_CODE, OUT_SINGLE, OUT_DOUBLE);
    end
    drain(1'b0);
    n_cmp++;
    if ({SINGLE_CNT, DOUBLE_CNT} !== {2'd0, 2'd0}) begin
      n_err++; $display("FAIL clean_counters got=%0d/%0d expected=0/0", SINGLE_CNT, DOUBLE_CNT);
    end
  endtask

  task automatic test_single();
    int w;
    send(1'b1, 11'h417, w);
    @(negedge CLK);
    @(negedge CLK);
    n_cmp++;
    if ({OUT_VALID, OUT_ID, OUT_DATA, OUT_ERROR_CODE, OUT_SINGLE, OUT_DOUBLE} !== {1'b1, 1'b1, 6'b000001, 4'b0101, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL single_fields got=%b_%b_%b_%b_%b%b expected=1_1_000001_0101_10",
               OUT_VALID, OUT_ID, OUT_DATA, OUT_ERROR_CODE, OUT_SINGLE, OUT_DOUBLE);
    end
    drain(1'b0);
    n_cmp++;
    if ({SINGLE_CNT, DOUBLE_CNT} !== {2'd1, 2'd0}) begin
      n_err++; $display("FAIL single_counters got=%0d/%0d expected=1/0", SINGLE_CNT, DOUBLE_CNT);
    end
  endtask

  task automatic test_double();
    int w;
    send(1'b0, 11'h517, w);
    @(negedge CLK);
    @(negedge CLK);
    n_cmp++;
    if ({OUT_VALID, OUT_ERROR_CODE, OUT_SINGLE, OUT_DOUBLE} !== {1'b1, 4'b1100, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL double_fields got=%b_%b_%b%b expected=1_1100_01",
               OUT_VALID, OUT_ERROR_CODE, OUT_SINGLE, OUT_DOUBLE);
    end
    drain(1'b0);
    n_cmp++;
    if ({SINGLE_CNT, DOUBLE_CNT} !== {2'd1, 2'd1}) begin
      n_err++; $display("FAIL double_counters got=%0d/%0d expected=1/1", SINGLE_CNT, DOUBLE_CNT);
    end
  endtask

  task automatic test_back_to_back();
    int          w;
    logic [11:1] cw_b;
    clear_cnt();
    cw_b = encode(6'($urandom_range(0, 63)));
    OUT_READY = 1'b0;
    send(1'b1, 11'h417, w);
    @(negedge CLK);
    @(negedge CLK);
    REQ0 = 1'b1; CW0 = cw_b;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_cmp++;
      if ({OUT_VALID, OUT_ID, OUT_DATA, OUT_ERROR_CODE, OUT_SINGLE, OUT_DOUBLE, GNT0, GNT1, SINGLE_CNT} !==
          {1'b1, exp_q[0], 1'b0, 1'b0, 2'd1}) begin
        n_err++;
        $display("FAIL backpressure_hold cyc=%0d got=%b_%b%b%b%b%b_%b%b_%0d expected=1_%b_00_1", i, OUT_VALID,
                 OUT_ID, OUT_DATA, OUT_ERROR_CODE, OUT_SINGLE, OUT_DOUBLE, GNT0, GNT1, SINGLE_CNT, exp_q[0]);
      end
    end
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    send(1'b0, cw_b, w);
    @(negedge CLK);
    n_cmp++;
    if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL b2b_bubble got=%b expected=0", OUT_VALID); end
    drain(1'b0);
    n_cmp++;
    if ({SINGLE_CNT, DOUBLE_CNT} !== {2'd1, 2'd0}) begin
      n_err++; $display("FAIL b2b_counters got=%0d/%0d expected=1/0", SINGLE_CNT, DOUBLE_CNT);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    OUT_READY = 1'b1;
    send(1'b0, 11'h417, w);
    REQ1 = 1'b1; CW1 = 11'h407;
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({GNT0, GNT1, OUT_VALID, OUT_ID, OUT_DATA, OUT_ERROR_CODE, OUT_SINGLE, OUT_DOUBLE,
         SINGLE_CNT, DOUBLE_CNT} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs got=%b%b%b%b_%b_%b_%b%b_%b_%b expected=all_zero", GNT0, GNT1,
               OUT_VALID, OUT_ID, OUT_DATA, OUT_ERROR_CODE, OUT_SINGLE, OUT_DOUBLE, SINGLE_CNT, DOUBLE_CNT);
    end
    exp_q.delete();
    exp_last = 1'b1;
    @(negedge CLK);
    RST_N = 1'b1;
    REQ1 = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_contention();
    int   seen, cyc;
    logic exp_id;
    seen = 0; cyc = 0;
    exp_id = ~exp_last;
    CW0 = rand_cw(); CW1 = rand_cw();
    REQ0 = 1'b1; REQ1 = 1'b1; OUT_READY = 1'b1;
    while (seen < 4 && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      n_cmp++;
      if (GNT0 && GNT1) begin n_err++; $display("FAIL both_gnt got=11 expected=at_most_one"); end
      if (GNT0 || GNT1) begin
        n_cmp++;
        if ({GNT1, GNT0} !== (exp_id ? 2'b10 : 2'b01)) begin
          n_err++; $display("FAIL contention_order xfer=%0d got=%b expected_id=%0d", seen, {GNT1, GNT0}, exp_id);
        end
        exp_q.push_back(model(exp_id, exp_id ? CW1 : CW0));
        @(posedge CLK); #1;
        if (exp_id) CW1 = rand_cw(); else CW0 = rand_cw();
        exp_last = exp_id;
        exp_id   = ~exp_id;
        seen++;
      end
    end
    if (seen < 4) begin
      n_cmp++; n_err++;
      $display("FAIL contention_timeout got=%0d expected=4", seen);
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    drain(1'b0);
  endtask

  task automatic test_saturation();
    int w;
    clear_cnt();
    for (int i = 0; i < 4; i++) begin
      send(1'(i), 11'h417, w);
      drain(1'b0);
      if (i >= 2) begin
        n_cmp++;
        if ({SINGLE_CNT, DOUBLE_CNT} !== {2'd3, 2'd0}) begin
          n_err++; $display("FAIL sat_hold n=%0d got=%0d/%0d expected=3/0", i + 1, SINGLE_CNT, DOUBLE_CNT);
        end
      end
    end
    send(1'b0, 11'h417, w);
    CLR_CNT = 1'b1;
    @(posedge CLK); #1;
    CLR_CNT = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (SINGLE_CNT !== 2'd0) begin n_err++; $display("FAIL clr_wins got=%0d expected=0", SINGLE_CNT); end
    drain(1'b0);
    n_cmp++;
    if (SINGLE_CNT !== 2'd0) begin n_err++; $display("FAIL clr_after got=%0d expected=0", SINGLE_CNT); end
  endtask

  task automatic test_random();
    int            w, sc, dc;
    logic          id;
    logic [11:1]   cw;
    logic [RW-1:0] r;
    clear_cnt();
    sc = 0; dc = 0;
    for (int i = 0; i < 24; i++) begin
      id = 1'($urandom_range(0, 1));
      cw = rand_cw();
      r  = model(id, cw);
      if (r[1] && sc < 3) sc++;
      if (r[0] && dc < 3) dc++;
      OUT_READY = 1'b1;
      send(id, cw, w);
      drain(1'b1);
    end
    n_cmp++;
    if ({SINGLE_CNT, DOUBLE_CNT} !== {2'(sc), 2'(dc)}) begin
      n_err++; $display("FAIL random_counters got=%0d/%0d expected=%0d/%0d", SINGLE_CNT, DOUBLE_CNT, sc, dc);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_back_to_back();
    test_reset_mid();
    test_contention();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
